// File: rtl/noc_local_ni_pkg.sv
// Shared flit definitions for the mesh NI: global bus width, flit field positions,
// the flit record and a packing helper.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef FLIT_DST_LSB
`define FLIT_DST_LSB 0
`endif
`ifndef FLIT_SRC_LSB
`define FLIT_SRC_LSB 3
`endif
`ifndef FLIT_PAYLOAD_LSB
`define FLIT_PAYLOAD_LSB 6
`endif

package noc_local_ni_pkg;
    localparam int FLIT_W    = `DATA_WIDTH;
    localparam int ADDR_W    = `FLIT_SRC_LSB - `FLIT_DST_LSB;
    localparam int PAYLOAD_W = FLIT_W - `FLIT_PAYLOAD_LSB;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [ADDR_W-1:0]    src;
        logic [ADDR_W-1:0]    dst;
    } flit_t;

    function automatic flit_t pack_flit(input logic [PAYLOAD_W-1:0] payload,
                                        input logic [ADDR_W-1:0]    src,
                                        input logic [ADDR_W-1:0]    dst);
        flit_t f;
        f.payload = payload;
        f.src     = src;
        f.dst     = dst;
        return f;
    endfunction
endpackage

// File: rtl/ni_sync_fifo.sv
// First-word-fall-through synchronous FIFO with extra-MSB pointers; a write to a
// full FIFO is taken only when a read frees the head slot on the same edge.
module ni_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Storage is cleared too so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end
endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: packs core requests into flits towards the router and
// buffers ejected flits for the core, with overflow/misroute tracking.
module noc_local_ni
    import noc_local_ni_pkg::*;
#(
    parameter logic [2:0] NODE_ADDRESS = 3'd1,
    parameter int         TX_DEPTH     = 4,
    parameter int         RX_DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    input  logic [2:0]             tx_dst,
    input  logic [25:0]            tx_payload,
    output logic [`DATA_WIDTH-1:0] LOCAL_DATA_IN,
    output logic                   LOCAL_DATA_VALID_IN,
    input  logic                   LOCAL_FULL_OUT,
    input  logic [`DATA_WIDTH-1:0] LOCAL_DATA_OUT,
    input  logic                   LOCAL_DATA_VALID_OUT,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [2:0]             rx_src,
    output logic [2:0]             rx_dst,
    output logic [25:0]            rx_payload,
    output logic                   rx_overflow,
    output logic                   rx_misroute,
    input  logic                   err_clr,
    output logic [7:0]             rx_drop_cnt,
    output logic [15:0]            tx_sent_cnt
);
    flit_t tx_wr_flit;
    flit_t tx_head;
    flit_t rx_head;
    logic  tx_full;
    logic  tx_empty;
    logic  tx_push;
    logic  rx_full;
    logic  rx_empty;
    logic  rx_pop;
    logic  rx_drop;
    logic  rx_bad_dst;

    assign tx_ready            = !tx_full;
    assign tx_push             = tx_valid && tx_ready;
    assign tx_wr_flit          = pack_flit(tx_payload, NODE_ADDRESS, tx_dst);
    assign LOCAL_DATA_VALID_IN = !tx_empty && !LOCAL_FULL_OUT;
    assign LOCAL_DATA_IN       = tx_head;

    ni_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tx_push),
        .wr_data (tx_wr_flit),
        .rd_en   (LOCAL_DATA_VALID_IN),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    // The router cannot be stalled: every ejected flit is offered to the RX buffer.
    assign rx_valid   = !rx_empty;
    assign rx_pop     = rx_valid && rx_ready;
    assign rx_drop    = LOCAL_DATA_VALID_OUT && rx_full && !rx_pop;
    assign rx_bad_dst = LOCAL_DATA_VALID_OUT &&
                        (LOCAL_DATA_OUT[`FLIT_DST_LSB +: 3] != NODE_ADDRESS);
    assign rx_src     = rx_head.src;
    assign rx_dst     = rx_head.dst;
    assign rx_payload = rx_head.payload;

    ni_sync_fifo #(.WIDTH(FLIT_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (LOCAL_DATA_VALID_OUT),
        .wr_data (LOCAL_DATA_OUT),
        .rd_en   (rx_pop),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_overflow <= 1'b0;
            rx_misroute <= 1'b0;
            rx_drop_cnt <= '0;
        end else if (err_clr) begin
            rx_overflow <= 1'b0;
            rx_misroute <= 1'b0;
            rx_drop_cnt <= '0;
        end else begin
            if (rx_drop) begin
                rx_overflow <= 1'b1;
                if (rx_drop_cnt != 8'hFF) begin
                    rx_drop_cnt <= rx_drop_cnt + 8'd1;
                end
            end
            if (rx_bad_dst) begin
                rx_misroute <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sent_cnt <= '0;
        end else if (LOCAL_DATA_VALID_IN) begin
            tx_sent_cnt <= tx_sent_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: directed tables and sequences for the corner cases, then
// randomized traffic against a queue-based model of the NI.
module tb_noc_local_ni;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_valid;
    logic        tx_ready;
    logic [2:0]  tx_dst;
    logic [25:0] tx_payload;
    logic [31:0] LOCAL_DATA_IN;
    logic        LOCAL_DATA_VALID_IN;
    logic        LOCAL_FULL_OUT;
    logic [31:0] LOCAL_DATA_OUT;
    logic        LOCAL_DATA_VALID_OUT;
    logic        rx_valid;
    logic        rx_ready;
    logic [2:0]  rx_src;
    logic [2:0]  rx_dst;
    logic [25:0] rx_payload;
    logic        rx_overflow;
    logic        rx_misroute;
    logic        err_clr;
    logic [7:0]  rx_drop_cnt;
    logic [15:0] tx_sent_cnt;

    int n_cmp = 0;
    int n_err = 0;

    noc_local_ni #(.NODE_ADDRESS(3'd1), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .tx_valid             (tx_valid),
        .tx_ready             (tx_ready),
        .tx_dst               (tx_dst),
        .tx_payload           (tx_payload),
        .LOCAL_DATA_IN        (LOCAL_DATA_IN),
        .LOCAL_DATA_VALID_IN  (LOCAL_DATA_VALID_IN),
        .LOCAL_FULL_OUT       (LOCAL_FULL_OUT),
        .LOCAL_DATA_OUT       (LOCAL_DATA_OUT),
        .LOCAL_DATA_VALID_OUT (LOCAL_DATA_VALID_OUT),
        .rx_valid             (rx_valid),
        .rx_ready             (rx_ready),
        .rx_src               (rx_src),
        .rx_dst               (rx_dst),
        .rx_payload           (rx_payload),
        .rx_overflow          (rx_overflow),
        .rx_misroute          (rx_misroute),
        .err_clr              (err_clr),
        .rx_drop_cnt          (rx_drop_cnt),
        .tx_sent_cnt          (tx_sent_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [25:0] p;
        logic        full;
        logic        exp_rdy;
        logic        exp_stb;
        logic        chk_d;
        logic [31:0] exp_d;
    } txvec_t;

    function automatic logic [31:0] mk(input logic [25:0] p, input logic [2:0] s,
                                       input logic [2:0] d);
        return {p, s, d};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        txvec_t      tv [11];
        logic [25:0] exp_rx [4];
        logic [31:0] txq [$];
        logic [31:0] rxq [$];
        bit          m_ovf;
        bit          m_mis;
        int          m_drop;
        logic [15:0] m_sent;

        rst_n = 1'b0;
        tx_valid = 1'b0; tx_dst = '0; tx_payload = '0;
        LOCAL_FULL_OUT = 1'b0; LOCAL_DATA_OUT = '0; LOCAL_DATA_VALID_OUT = 1'b0;
        rx_ready = 1'b0; err_clr = 1'b0;

        // ---- reset values ----
        tick(); tick();
        @(negedge clk);
        chk("rst_data_in", LOCAL_DATA_IN, 32'h0);
        chk("rst_strobe", LOCAL_DATA_VALID_IN, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_fields", {rx_payload, rx_src, rx_dst}, 32'h0);
        chk("rst_flags", {rx_overflow, rx_misroute}, 0);
        chk("rst_counters", {rx_drop_cnt, tx_sent_cnt}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // ---- single send ----
        tx_valid = 1'b1; tx_dst = 3'd5; tx_payload = 26'h12345;
        @(negedge clk);
        chk("send_ready", tx_ready, 1);
        chk("send_no_early_strobe", LOCAL_DATA_VALID_IN, 0);
        tick();
        tx_valid = 1'b0;
        @(negedge clk);
        chk("send_strobe", LOCAL_DATA_VALID_IN, 1);
        chk("send_flit", LOCAL_DATA_IN, 32'h048D14D);
        tick();
        @(negedge clk);
        chk("send_cnt", tx_sent_cnt, 16'd1);
        chk("send_idle_strobe", LOCAL_DATA_VALID_IN, 0);
        tick();

        // ---- TX backpressure table ----
        tv[0]  = '{1, 26'd1, 1, 1, 0, 0, 32'h0};
        tv[1]  = '{1, 26'd2, 1, 1, 0, 0, 32'h0};
        tv[2]  = '{1, 26'd3, 1, 1, 0, 0, 32'h0};
        tv[3]  = '{1, 26'd4, 1, 1, 0, 0, 32'h0};
        tv[4]  = '{1, 26'd5, 1, 0, 0, 0, 32'h0};
        tv[5]  = '{1, 26'd5, 0, 0, 1, 1, mk(26'd1, 3'd1, 3'd2)};
        tv[6]  = '{1, 26'd5, 0, 1, 1, 1, mk(26'd2, 3'd1, 3'd2)};
        tv[7]  = '{0, 26'd0, 0, 1, 1, 1, mk(26'd3, 3'd1, 3'd2)};
        tv[8]  = '{0, 26'd0, 0, 1, 1, 1, mk(26'd4, 3'd1, 3'd2)};
        tv[9]  = '{0, 26'd0, 0, 1, 1, 1, mk(26'd5, 3'd1, 3'd2)};
        tv[10] = '{0, 26'd0, 0, 1, 0, 0, 32'h0};
        tx_dst = 3'd2;
        for (int i = 0; i < 11; i++) begin
            tx_valid = tv[i].v; tx_payload = tv[i].p; LOCAL_FULL_OUT = tv[i].full;
            @(negedge clk);
            chk($sformatf("bp%0d_ready", i), tx_ready, tv[i].exp_rdy);
            chk($sformatf("bp%0d_strobe", i), LOCAL_DATA_VALID_IN, tv[i].exp_stb);
            if (tv[i].chk_d) chk($sformatf("bp%0d_data", i), LOCAL_DATA_IN, tv[i].exp_d);
            tick();
        end
        @(negedge clk);
        chk("bp_sent_cnt", tx_sent_cnt, 16'd6);
        tick();

        // ---- RX stream, core always ready ----
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            LOCAL_DATA_VALID_OUT = (i < 6);
            LOCAL_DATA_OUT = mk(26'h500 + 26'(i), 3'd2, 3'd1);
            @(negedge clk);
            if (i > 0 && i < 7) begin
                chk($sformatf("rxs%0d_valid", i), rx_valid, 1);
                chk($sformatf("rxs%0d_flit", i), {rx_payload, rx_src, rx_dst},
                    mk(26'h500 + 26'(i - 1), 3'd2, 3'd1));
            end else begin
                chk($sformatf("rxs%0d_valid", i), rx_valid, 0);
            end
            tick();
        end
        @(negedge clk);
        chk("rxs_flags", {rx_overflow, rx_misroute, rx_drop_cnt}, 0);
        tick();

        // ---- RX overflow ----
        rx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            LOCAL_DATA_VALID_OUT = 1'b1;
            LOCAL_DATA_OUT = mk(26'h100 + 26'(i), 3'd2, 3'd1);
            tick();
        end
        LOCAL_DATA_VALID_OUT = 1'b0;
        @(negedge clk);
        chk("ovf_flag", rx_overflow, 1);
        chk("ovf_drop_cnt", rx_drop_cnt, 8'd2);
        chk("ovf_head", rx_payload, 26'h100);
        tick();
        rx_ready = 1'b1;
        LOCAL_DATA_VALID_OUT = 1'b1;
        LOCAL_DATA_OUT = mk(26'h200, 3'd2, 3'd1);
        @(negedge clk);
        chk("ovf_pop_head", rx_payload, 26'h100);
        tick();
        LOCAL_DATA_VALID_OUT = 1'b0;
        exp_rx = '{26'h101, 26'h102, 26'h103, 26'h200};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("ovf_drain%0d_valid", i), rx_valid, 1);
            chk($sformatf("ovf_drain%0d", i), rx_payload, exp_rx[i]);
            tick();
        end
        @(negedge clk);
        chk("ovf_drained", rx_valid, 0);
        chk("ovf_cnt_kept", rx_drop_cnt, 8'd2);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", {rx_overflow, rx_drop_cnt}, 0);
        tick();

        // ---- misroute ----
        LOCAL_DATA_VALID_OUT = 1'b1;
        LOCAL_DATA_OUT = mk(26'h3AA, 3'd2, 3'd3);
        tick();
        LOCAL_DATA_VALID_OUT = 1'b0;
        @(negedge clk);
        chk("mis_delivered", {rx_valid, rx_payload, rx_dst}, {1'b1, 26'h3AA, 3'd3});
        chk("mis_flag", rx_misroute, 1);
        tick();
        LOCAL_DATA_VALID_OUT = 1'b1;
        LOCAL_DATA_OUT = mk(26'h3AB, 3'd2, 3'd4);
        err_clr = 1'b1;
        tick();
        LOCAL_DATA_VALID_OUT = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        chk("mis_clr_priority", rx_misroute, 0);
        chk("mis_clr_delivered", rx_payload, 26'h3AB);
        tick();

        // ---- reset mid-traffic ----
        rx_ready = 1'b0;
        LOCAL_FULL_OUT = 1'b1;
        tx_valid = 1'b1; tx_payload = 26'h777; tx_dst = 3'd6;
        LOCAL_DATA_VALID_OUT = 1'b1; LOCAL_DATA_OUT = mk(26'h888, 3'd0, 3'd1);
        tick(); tick();
        tx_valid = 1'b0; LOCAL_DATA_VALID_OUT = 1'b0;
        @(negedge clk);
        chk("mid_pre_rx_valid", rx_valid, 1);
        chk("mid_pre_tx_head", LOCAL_DATA_IN, mk(26'h777, 3'd1, 3'd6));
        #1;
        LOCAL_FULL_OUT = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_strobe", LOCAL_DATA_VALID_IN, 0);
        chk("mid_rst_data", LOCAL_DATA_IN, 32'h0);
        chk("mid_rst_ready_valid", {tx_ready, rx_valid}, 2'b10);
        chk("mid_rst_rx_fields", {rx_payload, rx_src, rx_dst}, 32'h0);
        chk("mid_rst_counters", {tx_sent_cnt, rx_drop_cnt, rx_overflow, rx_misroute}, 0);
        tick(); tick();
        rst_n = 1'b1;
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("mid_post%0d", i), {LOCAL_DATA_VALID_IN, rx_valid}, 0);
            tick();
        end

        // ---- randomized traffic against queue model ----
        m_ovf = 0; m_mis = 0; m_drop = 0; m_sent = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            bit sat_phase;
            bit exp_stb;
            bit tx_acc;
            bit rx_full_b;
            bit rx_pop_m;
            bit drop_ev;
            bit mis_ev;
            sat_phase = (cyc >= 1000 && cyc < 1300);
            tx_valid = ($urandom_range(0, 9) < 7);
            tx_dst = 3'($urandom_range(0, 7));
            tx_payload = 26'($urandom);
            LOCAL_FULL_OUT = ($urandom_range(0, 9) < 3);
            LOCAL_DATA_VALID_OUT = sat_phase ? 1'b1 : ($urandom_range(0, 9) < 6);
            LOCAL_DATA_OUT = {26'($urandom), 3'($urandom_range(0, 7)),
                              ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd1};
            rx_ready = sat_phase ? 1'b0 : ($urandom_range(0, 1) == 1);
            err_clr = sat_phase ? 1'b0 : ($urandom_range(0, 99) < 3);
            @(negedge clk);
            chk("rnd_tx_ready", tx_ready, (txq.size() < 4));
            exp_stb = (txq.size() > 0) && !LOCAL_FULL_OUT;
            chk("rnd_strobe", LOCAL_DATA_VALID_IN, exp_stb);
            if (txq.size() > 0) chk("rnd_tx_data", LOCAL_DATA_IN, txq[0]);
            chk("rnd_rx_valid", rx_valid, (rxq.size() > 0));
            if (rxq.size() > 0) chk("rnd_rx_head", {rx_payload, rx_src, rx_dst}, rxq[0]);
            chk("rnd_flags", {rx_overflow, rx_misroute}, {m_ovf, m_mis});
            chk("rnd_drop_cnt", rx_drop_cnt, m_drop);
            chk("rnd_sent_cnt", tx_sent_cnt, m_sent);

            tx_acc = tx_valid && (txq.size() < 4);
            if (exp_stb) begin
                void'(txq.pop_front());
                m_sent = m_sent + 16'd1;
            end
            if (tx_acc) txq.push_back(mk(tx_payload, 3'd1, tx_dst));
            rx_full_b = (rxq.size() == 4);
            rx_pop_m = (rxq.size() > 0) && rx_ready;
            if (rx_pop_m) void'(rxq.pop_front());
            drop_ev = 0;
            if (LOCAL_DATA_VALID_OUT) begin
                if (!rx_full_b || rx_pop_m) rxq.push_back(LOCAL_DATA_OUT);
                else drop_ev = 1;
            end
            mis_ev = LOCAL_DATA_VALID_OUT && (LOCAL_DATA_OUT[2:0] != 3'd1);
            if (err_clr) begin
                m_ovf = 0; m_mis = 0; m_drop = 0;
            end else begin
                if (drop_ev) begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
                if (mis_ev) m_mis = 1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/noc_local_ni.md
# noc_local_ni

Local network interface for one 2x4 mesh node: sits between the processing core and the router's LOCAL port. On the TX side it packs core requests into 32-bit flits carrying source and destination addresses, buffers them, and injects them into the router's local input FIFO under the router's full signal. On the RX side it absorbs every flit the router ejects on its LOCAL output, which has no backpressure, into a receive buffer. It then hands those flits to the core over a valid/ready handshake and flags overflow or misdelivery.

## Interface
- NODE_ADDRESS, 3'b1, this node's mesh address (0..7); inserted as source, checked against RX destination.
- TX_DEPTH, 4, TX buffer entries (power of two, >=2).
- RX_DEPTH, 4, RX buffer entries (power of two, >=2).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low; no other reset exists.
- tx_valid  in  1  core request valid.
- tx_ready  out  1  TX buffer not full; transfer when tx_valid && tx_ready.
- tx_dst  in  3  destination node address.
- tx_payload  in  26  payload.
- LOCAL_DATA_IN  out  `DATA_WIDTH  flit to router local input.
- LOCAL_DATA_VALID_IN  out  1  flit write strobe to router.
- LOCAL_FULL_OUT  in  1  router local input FIFO full.
- LOCAL_DATA_OUT  in  `DATA_WIDTH  flit ejected by router.
- LOCAL_DATA_VALID_OUT  in  1  ejected flit valid; must be accepted that cycle.
- rx_valid  out  1  RX buffer not empty.
- rx_ready  in  1  core accepts; pop when rx_valid && rx_ready.
- rx_src, rx_dst  out  3 each  fields of head flit.
- rx_payload  out  26  payload of head flit.
- rx_overflow  out  1  sticky: a flit was dropped.
- rx_misroute  out  1  sticky: a flit arrived with dst != NODE_ADDRESS.
- err_clr  in  1  synchronous clear of both sticky flags and rx_drop_cnt.
- rx_drop_cnt  out  8  dropped-flit count, saturates at 255.
- tx_sent_cnt  out  16  injected-flit count, wraps.

## Operation
- Flit format: [31:6] payload, [5:3] src, [2:0] dst. Router routing uses bits [2:0] only.
- TX push: on tx_valid && tx_ready, write {tx_payload, NODE_ADDRESS, tx_dst}.
- TX inject: LOCAL_DATA_VALID_IN = !tx_empty && !LOCAL_FULL_OUT, combinational. LOCAL_DATA_IN = head flit. The TX buffer pops in the same cycle. No flit is ever presented while LOCAL_FULL_OUT=1. The data bus holds the head flit even when the strobe is low.
- Simultaneous TX push and pop when full: tx_ready is 0 when full; a push is never accepted on a full buffer, even if a pop occurs that cycle.
- RX push: every cycle with LOCAL_DATA_VALID_OUT=1 writes LOCAL_DATA_OUT.
  - Push to a full buffer with a simultaneous pop is accepted (occupancy unchanged).
  - Push to a full buffer without a pop drops the flit, sets rx_overflow, and increments rx_drop_cnt with saturation.
- Misroute: if LOCAL_DATA_OUT[2:0] != NODE_ADDRESS on a push, set rx_misroute. The flit is still buffered or dropped by the normal rules.
- err_clr has priority over set in the same cycle.
- tx_sent_cnt increments on each LOCAL_DATA_VALID_IN=1.
- Pointers are log2(DEPTH)+1 bits. full = MSBs differ and LSBs equal; empty = pointers equal. Wrap-around is natural.

## Timing
- Reset values:
  - LOCAL_DATA_VALID_IN=0, LOCAL_DATA_IN=0.
  - tx_ready=1, rx_valid=0, rx_src/rx_dst/rx_payload=0.
  - Sticky flags 0, counters 0. All pointers 0.
  - Reset mid-operation discards all buffered flits immediately.
- TX latency: a flit accepted at edge N appears on LOCAL_DATA_IN during cycle N+1. It is strobed during cycle N+1 if LOCAL_FULL_OUT=0 in that cycle.
- RX latency: a flit pushed at edge N gives rx_valid=1 during cycle N+1, with fields from the head entry (first-word-fall-through).
- Full throughput of one flit per cycle in each direction when not blocked.
- Flags and counters update at the edge following the event.

## Structure
- Shared include global.v provides `DATA_WIDTH. Add the field macros `FLIT_DST_LSB=0, `FLIT_SRC_LSB=3, `FLIT_PAYLOAD_LSB=6 there for reuse by routers and testbenches.
- One sub-module, ni_sync_fifo: parameterized (WIDTH, DEPTH), first-word-fall-through, with full/empty outputs. It is instantiated twice, for TX and RX. Counters, flags and flit packing stay in the top.

## Test plan
- Reset then a single send: NODE_ADDRESS=1, tx_dst=5, tx_payload=26'h12345. Required: LOCAL_DATA_IN=32'h048D_14D (payload<<6 | 1<<3 | 5) with strobe one cycle after acceptance; tx_sent_cnt=1.
- Backpressure: hold LOCAL_FULL_OUT=1 and push 5 requests. Required: tx_ready drops after 4 and no strobe. Release full: 4 flits are strobed on consecutive cycles in order, and the 5th is then accepted.
- RX stream with rx_ready=1: inject 6 flits dst=1 on consecutive cycles. Required: the same 6 appear on rx_* in order, one cycle later each; no flags set.
- RX overflow: rx_ready=0, inject 6 flits. Required: first 4 buffered, rx_overflow=1, rx_drop_cnt=2. Full-with-pop push is accepted; err_clr clears both.
- Misroute: inject a flit with dst=3. Required: delivered normally, rx_misroute=1. err_clr asserted in the same cycle as a new misroute leaves the flag 0.
- Reset mid-traffic: assert rst_n=0 with both buffers half full. Required: outputs return to their reset values asynchronously, and no stale flit is emitted after release.
